mdu_ctrl: RTL and testbench

Multi-cycle multiply/divide controller for the E stage of the five-stage MIPS pipeline. It accepts decoded MDU operations (mult, multu, div, divu, mfhi, mflo, mthi, mtlo) with their operands, and sequences the fixed-latency multiply and divide. It owns the HI/LO registers, returns HI/LO for mfhi/mflo, and raises a stall toward the hazard unit while a later MDU instruction in D would conflict. It also honours exception cancellation coming from the M stage.

---
 rtl/mdu_ctrl.sv | 141 ++++++++++++++
 tb/tb_mdu_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// Multi-cycle MIPS multiply/divide controller. It owns HI/LO, commits each result after a fixed latency,
// and stalls the hazard unit while a D-stage MDU instruction would collide with an operation in flight.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mdu_start,
    input  logic [4:0]  mdu_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        req,
    input  logic        d_mdu_class,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mdu_out
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [4:0] OP_MULT  = 5'd0;
    localparam logic [4:0] OP_MULTU = 5'd1;
    localparam logic [4:0] OP_DIV   = 5'd2;
    localparam logic [4:0] OP_DIVU  = 5'd3;
    localparam logic [4:0] OP_MFHI  = 5'd4;
    localparam logic [4:0] OP_MFLO  = 5'd5;
    localparam logic [4:0] OP_MTHI  = 5'd6;
    localparam logic [4:0] OP_MTLO  = 5'd7;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     hi_q, hi_d, lo_q, lo_d;
    logic [31:0]     pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;

    logic            is_signed;
    logic [63:0]     prod;
    logic [31:0]     a_mag, b_mag, q_mag, r_mag, div_q, div_r;
    logic            arith_op;

    // Signed divide works on magnitudes so INT_MIN / -1 wraps instead of trapping.
    always_comb begin
        is_signed = (mdu_op == OP_MULT) || (mdu_op == OP_DIV);
        if (is_signed)
            prod = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
        else
            prod = {32'd0, src_a} * {32'd0, src_b};
        a_mag = (is_signed && src_a[31]) ? -src_a : src_a;
        b_mag = (is_signed && src_b[31]) ? -src_b : src_b;
        q_mag = (b_mag == 32'd0) ? 32'd0 : a_mag / b_mag;
        r_mag = (b_mag == 32'd0) ? 32'd0 : a_mag % b_mag;
        div_q = (is_signed && (src_a[31] ^ src_b[31])) ? -q_mag : q_mag;
        div_r = (is_signed && src_a[31]) ? -r_mag : r_mag;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;

        case (state_q)
            IDLE: begin
                if (mdu_start && !req) begin
                    case (mdu_op)
                        OP_MULT, OP_MULTU: begin
                            {pend_hi_d, pend_lo_d} = prod;
                            cnt_d   = CW'(MULT_CYCLES);
                            state_d = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            // Divide by zero recommits the current HI/LO, leaving them unchanged.
                            if (src_b == 32'd0) begin
                                pend_hi_d = hi_q;
                                pend_lo_d = lo_q;
                            end else begin
                                pend_hi_d = div_r;
                                pend_lo_d = div_q;
                            end
                            cnt_d   = CW'(DIV_CYCLES);
                            state_d = RUN;
                        end
                        OP_MTHI: hi_d = src_a;
                        OP_MTLO: lo_d = src_a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    always_comb begin
        arith_op = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU) ||
                   (mdu_op == OP_DIV)  || (mdu_op == OP_DIVU);
        busy     = (state_q == RUN);
        stall    = d_mdu_class & (busy | (mdu_start & ~req & arith_op));
        hi       = hi_q;
        lo       = lo_q;
        case (mdu_op)
            OP_MFHI: mdu_out = hi_q;
            OP_MFLO: mdu_out = lo_q;
            default: mdu_out = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: expected HI/LO are pushed at launch and popped when busy drops.
module tb_mdu_ctrl;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset, mdu_start, req, d_mdu_class;
    logic [4:0]  mdu_op;
    logic [31:0] src_a, src_b;
    logic        busy, stall;
    logic [31:0] hi, lo, mdu_out;

    int total = 0;
    int bad   = 0;
    logic [63:0] sb_q[$];
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .mdu_start(mdu_start), .mdu_op(mdu_op),
        .src_a(src_a), .src_b(src_b), .req(req), .d_mdu_class(d_mdu_class),
        .busy(busy), .stall(stall), .hi(hi), .lo(lo), .mdu_out(mdu_out)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [63:0] model(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] h,
                                          input logic [31:0] l);
        longint sa, sb;
        int ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ia = a;
        ib = b;
        case (op)
            5'd0: return 64'(sa * sb);
            5'd1: return {32'd0, a} * {32'd0, b};
            5'd2: return (b == 0) ? {h, l} : {32'(ia % ib), 32'(ia / ib)};
            5'd3: return (b == 0) ? {h, l} : {a % b, a / b};
            default: return {h, l};
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n);
        logic [63:0] exp;
        int cyc, stall_n;
        sb_q.push_back(model(op, a, b, m_hi, m_lo));
        mdu_start = 1'b1; mdu_op = op; src_a = a; src_b = b; d_mdu_class = 1'b1;
        #1;
        stall_n = int'(stall);
        tick();
        mdu_start = 1'b0; mdu_op = 5'd31;
        #1;
        cyc = 0;
        while (busy === 1'b1 && cyc < 60) begin
            stall_n += int'(stall);
            cyc++;
            tick();
            #1;
        end
        check_val({tag, "_busy_cycles"}, 64'(cyc), 64'(n));
        check_val({tag, "_stall_cycles"}, 64'(stall_n), 64'(n + 1));
        check_val({tag, "_stall_off"}, 64'(stall), 64'd0);
        exp = sb_q.pop_front();
        check_val({tag, "_hilo"}, {hi, lo}, exp);
        m_hi = exp[63:32];
        m_lo = exp[31:0];
        mdu_op = 5'd5;
        #1;
        check_val({tag, "_mflo"}, 64'(mdu_out), 64'(exp[31:0]));
        d_mdu_class = 1'b0;
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [4:0]  rop;
        reset = 1'b1; mdu_start = 1'b0; req = 1'b0; d_mdu_class = 1'b0;
        mdu_op = 5'd31; src_a = 32'd0; src_b = 32'd0;
        tick(); tick();
        reset = 1'b0;
        #1;
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_hilo", {hi, lo}, 64'd0);
        check_val("rst_out", 64'(mdu_out), 64'd0);
        check_val("rst_stall", 64'(stall), 64'd0);

        // mthi / mtlo then read back
        mdu_start = 1'b1; mdu_op = 5'd6; src_a = 32'h12345678; d_mdu_class = 1'b1;
        #1;
        check_val("mthi_stall", 64'(stall), 64'd0);
        tick();
        mdu_start = 1'b0; mdu_op = 5'd4;
        #1;
        check_val("mthi_busy", 64'(busy), 64'd0);
        check_val("mfhi_out", 64'(mdu_out), 64'h12345678);
        mdu_start = 1'b1; mdu_op = 5'd7; src_a = 32'hCAFEF00D;
        tick();
        mdu_start = 1'b0; mdu_op = 5'd5; d_mdu_class = 1'b0;
        #1;
        check_val("mflo_out", 64'(mdu_out), 64'hCAFEF00D);
        m_hi = 32'h12345678; m_lo = 32'hCAFEF00D;

        run_op("mult", 5'd0, 32'hFFFFFFFE, 32'd3, MC);
        check_val("mult_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);
        run_op("multu", 5'd1, 32'hFFFFFFFE, 32'd3, MC);
        check_val("multu_const", {hi, lo}, 64'h00000002_FFFFFFFA);
        run_op("div", 5'd2, 32'hFFFFFFF9, 32'd2, DC);
        check_val("div_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        run_op("divu0", 5'd3, 32'd7, 32'd0, DC);
        check_val("divu0_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);

        // cancelled launch
        tick();
        mdu_start = 1'b1; mdu_op = 5'd0; src_a = 32'd9; src_b = 32'd9; req = 1'b1; d_mdu_class = 1'b1;
        #1;
        check_val("cancel_stall", 64'(stall), 64'd0);
        tick();
        mdu_start = 1'b0; req = 1'b0; d_mdu_class = 1'b0;
        #1;
        check_val("cancel_busy", 64'(busy), 64'd0);
        check_val("cancel_hilo", {hi, lo}, {m_hi, m_lo});

        for (int i = 0; i < 8; i++) begin
            rop = 5'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i == 3) ? 32'd0 : ((i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
            if (rop == 5'd2 && ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd5;
            run_op("rand", rop, ra, rb, (rop < 5'd2) ? MC : DC);
        end

        // reset three cycles into a divide
        mdu_start = 1'b1; mdu_op = 5'd2; src_a = 32'd100; src_b = 32'd7;
        tick();
        mdu_start = 1'b0; mdu_op = 5'd31;
        tick(); tick(); tick();
        #1;
        check_val("mid_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check_val("rst_mid_busy", 64'(busy), 64'd0);
        check_val("rst_mid_hilo", {hi, lo}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
